envase_vedacao: RTL and testbench
=================================

Name: envase_vedacao

Overview:
Bottle filling and corking station controller, directly downstream of the cork stock block. Drives the conveyor, fill valve and corking actuator for one bottle at a time. Consumes line cork availability (rolhas_linha) from the stock block. Returns a one-cycle done pulse per corked bottle; the stock block uses this pulse to decrement its line count. Also keeps per-batch and batch-total production counters.

Parameters:
FILL_TIMEOUT, 8'd50, max cycles in ENCHIMENTO without sensor_nivel before fault
CAP_CYCLES, 8'd4, cycles the corking actuator (vedar) stays asserted
BATCH_SIZE, 4'd12, bottles per batch

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; forces IDLE and clears all counters and outputs
start  in  1  run enable (level)
sensor_garrafa  in  1  bottle present under the station
sensor_nivel  in  1  fill level reached
rolhas_linha  in  8  corks currently on line, from the stock block
reconhece_falha  in  1  operator fault acknowledge
motor_esteira  out  1  conveyor motor
valvula  out  1  fill valve
vedar  out  1  corking actuator
done  out  1  one-cycle pulse per corked bottle, to the stock block
alarme_sem_rolha  out  1  waiting for corks
alarme_enchimento  out  1  fill timeout fault (latched)
garrafas_lote  out  4  bottles in the current batch, 0..BATCH_SIZE-1
lotes  out  8  completed batches, saturating
estado  out  3  current state encoding, for debug

Behaviour:
- All outputs are registered (Moore). All inputs are sampled on the rising clk edge. Reset is synchronous, active-high and overrides everything.
- Reset values: state IDLE, every output 0, internal timer 0.
- State encoding: IDLE=0, TRANSPORTE=1, ENCHIMENTO=2, ESPERA_ROLHA=3, VEDACAO=4, SAIDA=5, FALHA=6.
- Output enables by state:
  - motor_esteira=1 only in TRANSPORTE and SAIDA.
  - valvula=1 only in ENCHIMENTO.
  - vedar=1 only in VEDACAO.
  - alarme_sem_rolha=1 only in ESPERA_ROLHA.
  - alarme_enchimento=1 only in FALHA.
- Transitions:
  - IDLE: start=1 -> TRANSPORTE.
  - TRANSPORTE:
    - start=0 -> IDLE.
    - else sensor_garrafa=1 -> ENCHIMENTO, timer cleared. The motor drops on the edge that enters ENCHIMENTO, i.e. 1-cycle latency from the sensor.
  - ENCHIMENTO: timer increments each cycle.
    - sensor_nivel=1 -> VEDACAO if rolhas_linha!=0, else ESPERA_ROLHA.
    - else timer==FILL_TIMEOUT-1 -> FALHA.
    - sensor_nivel wins over timeout in the same cycle.
  - ESPERA_ROLHA: rolhas_linha!=0 -> VEDACAO, timer cleared. The valve stays closed while waiting.
  - VEDACAO: timer counts. At timer==CAP_CYCLES-1 -> SAIDA, and done=1 for exactly the first SAIDA cycle. Vedar is therefore high for exactly CAP_CYCLES cycles.
  - SAIDA: waits for sensor_garrafa=0, then -> TRANSPORTE if start=1, else IDLE.
  - FALHA: all actuators 0. reconhece_falha=1 -> IDLE, which clears the alarm. The bottle is not counted.
- start=0 is honoured only in IDLE, TRANSPORTE and SAIDA. A bottle already in fill or cork completes.
- rolhas_linha is checked only on entry to VEDACAO. A drop to 0 during VEDACAO does not abort corking.
- Counters update in the same cycle done is registered high:
  - garrafas_lote increments.
  - At BATCH_SIZE-1, garrafas_lote wraps to 0 and lotes increments.
  - lotes saturates at 255; garrafas_lote still wraps.
- done is never asserted on consecutive cycles. Minimum spacing is the full cycle TRANSPORTE+ENCHIMENTO+VEDACAO+SAIDA.
- Timer is 8 bits and cleared on every state change. FILL_TIMEOUT and CAP_CYCLES must each be >=1.

Decomposition:
- Shared package envase_pkg holds:
  - the state encoding constants (IDLE..FALHA, 3 bits);
  - the default FILL_TIMEOUT, CAP_CYCLES and BATCH_SIZE values, shared with the stock block's integration top.
- One natural sub-module: contador_lote, holding the batch/bottle counter with wrap and saturation. Inputs: clk, reset, incr. Outputs: garrafas_lote, lotes.

Test Plan:
- Nominal bottle: reset, start=1, sensor_garrafa=1 at cycle 3, sensor_nivel=1 at cycle 10, rolhas_linha=5 -> vedar high 4 cycles, done single pulse, garrafas_lote=1, motor on in SAIDA until sensor_garrafa=0.
- No corks: rolhas_linha=0 at fill end -> ESPERA_ROLHA, alarme_sem_rolha=1, valvula=0. Set rolhas_linha=3 -> VEDACAO next cycle, done once.
- Fill timeout: sensor_nivel held 0 -> FALHA exactly 50 cycles after entering ENCHIMENTO, alarme_enchimento=1, no done. reconhece_falha=1 -> IDLE, alarm 0.
- Batch rollover: 12 bottles -> garrafas_lote 11 -> 0, lotes=1. Force 255 batches -> lotes stays 255.
- Stop mid-fill: start=0 during ENCHIMENTO -> bottle still corked, done pulses, then IDLE after SAIDA without re-entering TRANSPORTE.
- Reset mid-VEDACAO: reset=1 for one cycle -> next cycle all outputs 0, estado=0, counters 0, no done.

Source files
------------

// File: rtl/envase_pkg.sv
// rtl/envase_pkg.sv - shared state encoding and default parameters for the filling/corking station
package envase_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        TRANSPORTE   = 3'd1,
        ENCHIMENTO   = 3'd2,
        ESPERA_ROLHA = 3'd3,
        VEDACAO      = 3'd4,
        SAIDA        = 3'd5,
        FALHA        = 3'd6
    } estado_t;

    localparam logic [7:0] FILL_TIMEOUT_DEF = 8'd50;
    localparam logic [7:0] CAP_CYCLES_DEF   = 8'd4;
    localparam logic [3:0] BATCH_SIZE_DEF   = 4'd12;

endpackage

// File: rtl/contador_lote.sv
// rtl/contador_lote.sv - bottles-per-batch counter with wrap and saturating batch total
module contador_lote
    import envase_pkg::*;
#(
    parameter logic [3:0] BATCH_SIZE = BATCH_SIZE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       incr,
    output logic [3:0] garrafas_lote,
    output logic [7:0] lotes
);

    always_ff @(posedge clk) begin
        if (reset) begin
            garrafas_lote <= 4'd0;
            lotes         <= 8'd0;
        end else if (incr) begin
            if (garrafas_lote == BATCH_SIZE - 4'd1) begin
                garrafas_lote <= 4'd0;
                // batch total sticks at its ceiling while bottles keep wrapping
                if (lotes != 8'hFF) begin
                    lotes <= lotes + 8'd1;
                end
            end else begin
                garrafas_lote <= garrafas_lote + 4'd1;
            end
        end
    end

endmodule

// File: rtl/envase_vedacao.sv
// rtl/envase_vedacao.sv - one-bottle-at-a-time fill and cork station controller
module envase_vedacao
    import envase_pkg::*;
#(
    parameter logic [7:0] FILL_TIMEOUT = FILL_TIMEOUT_DEF,
    parameter logic [7:0] CAP_CYCLES   = CAP_CYCLES_DEF,
    parameter logic [3:0] BATCH_SIZE   = BATCH_SIZE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sensor_garrafa,
    input  logic       sensor_nivel,
    input  logic [7:0] rolhas_linha,
    input  logic       reconhece_falha,
    output logic       motor_esteira,
    output logic       valvula,
    output logic       vedar,
    output logic       done,
    output logic       alarme_sem_rolha,
    output logic       alarme_enchimento,
    output logic [3:0] garrafas_lote,
    output logic [7:0] lotes,
    output logic [2:0] estado
);

    estado_t    st;
    estado_t    nxt;
    logic [7:0] timer;
    logic       incr;

    always_comb begin
        nxt = st;
        unique case (st)
            IDLE:         if (start) nxt = TRANSPORTE;
            TRANSPORTE: begin
                if (!start)              nxt = IDLE;
                else if (sensor_garrafa) nxt = ENCHIMENTO;
            end
            ENCHIMENTO: begin
                // a level hit in the timeout cycle still completes the bottle
                if (sensor_nivel)                         nxt = (rolhas_linha != 8'd0) ? VEDACAO : ESPERA_ROLHA;
                else if (timer == FILL_TIMEOUT - 8'd1)    nxt = FALHA;
            end
            ESPERA_ROLHA: if (rolhas_linha != 8'd0) nxt = VEDACAO;
            VEDACAO:      if (timer == CAP_CYCLES - 8'd1) nxt = SAIDA;
            SAIDA:        if (!sensor_garrafa) nxt = start ? TRANSPORTE : IDLE;
            FALHA:        if (reconhece_falha) nxt = IDLE;
            default:      nxt = IDLE;
        endcase
    end

    assign incr = (st == VEDACAO) && (nxt == SAIDA);

    // outputs are decoded from the next state so they register alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            st                <= IDLE;
            timer             <= 8'd0;
            motor_esteira     <= 1'b0;
            valvula           <= 1'b0;
            vedar             <= 1'b0;
            done              <= 1'b0;
            alarme_sem_rolha  <= 1'b0;
            alarme_enchimento <= 1'b0;
        end else begin
            st                <= nxt;
            timer             <= (nxt != st) ? 8'd0 : timer + 8'd1;
            motor_esteira     <= (nxt == TRANSPORTE) || (nxt == SAIDA);
            valvula           <= (nxt == ENCHIMENTO);
            vedar             <= (nxt == VEDACAO);
            done              <= incr;
            alarme_sem_rolha  <= (nxt == ESPERA_ROLHA);
            alarme_enchimento <= (nxt == FALHA);
        end
    end

    assign estado = st;

    contador_lote #(
        .BATCH_SIZE (BATCH_SIZE)
    ) u_contador_lote (
        .clk           (clk),
        .reset         (reset),
        .incr          (incr),
        .garrafas_lote (garrafas_lote),
        .lotes         (lotes)
    );

endmodule

// File: tb/tb_envase_vedacao.sv
// tb/tb_envase_vedacao.sv - self-checking bench for the filling/corking station controller
module tb_envase_vedacao;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sensor_garrafa;
    logic       sensor_nivel;
    logic [7:0] rolhas_linha;
    logic       reconhece_falha;
    logic       motor_esteira;
    logic       valvula;
    logic       vedar;
    logic       done;
    logic       alarme_sem_rolha;
    logic       alarme_enchimento;
    logic [3:0] garrafas_lote;
    logic [7:0] lotes;
    logic [2:0] estado;

    int checks   = 0;
    int failures = 0;
    int n_ok     = 0;

    envase_vedacao dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .sensor_garrafa    (sensor_garrafa),
        .sensor_nivel      (sensor_nivel),
        .rolhas_linha      (rolhas_linha),
        .reconhece_falha   (reconhece_falha),
        .motor_esteira     (motor_esteira),
        .valvula           (valvula),
        .vedar             (vedar),
        .done              (done),
        .alarme_sem_rolha  (alarme_sem_rolha),
        .alarme_enchimento (alarme_enchimento),
        .garrafas_lote     (garrafas_lote),
        .lotes             (lotes),
        .estado            (estado)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // expected counters follow directly from the number of corked bottles
    task automatic check_counters();
        int b;
        b = n_ok / 12;
        check("garrafas_lote", garrafas_lote, n_ok % 12);
        check("lotes", lotes, (b > 255) ? 255 : b);
    endtask

    // entered from TRANSPORTE; fill_len cycles in fill, level on the last one
    task automatic run_bottle(input int fill_len, input bit corks_now, input int wait_corks,
                              input int dwell, input bit stop_mid, input bit full);
        int cnt;
        sensor_garrafa = 1'b1;
        tick();
        if (full) begin
            check("fill_estado", estado, 2);
            check("fill_valvula", valvula, 1);
            check("fill_motor", motor_esteira, 0);
        end
        if (stop_mid) start = 1'b0;
        sensor_nivel = 1'b0;
        for (int i = 1; i < fill_len; i++) begin
            tick();
            if (full) check("fill_hold", estado, 2);
        end
        sensor_nivel = 1'b1;
        rolhas_linha = corks_now ? 8'($urandom_range(1, 255)) : 8'd0;
        tick();
        sensor_nivel = 1'b0;
        if (!corks_now) begin
            check("wait_estado", estado, 3);
            check("wait_alarme", alarme_sem_rolha, 1);
            check("wait_valvula", valvula, 0);
            for (int i = 0; i < wait_corks; i++) begin
                tick();
                check("wait_hold", estado, 3);
            end
            rolhas_linha = 8'd3;
            tick();
        end
        check("cap_estado", estado, 4);
        rolhas_linha = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd7;
        cnt = 0;
        while (vedar === 1'b1 && cnt < 10) begin
            if (full) check("cap_no_done", done, 0);
            cnt++;
            tick();
        end
        check("vedar_len", cnt, 4);
        n_ok++;
        check("done_pulse", done, 1);
        check("exit_estado", estado, 5);
        check("exit_motor", motor_esteira, 1);
        check_counters();
        for (int i = 0; i < dwell; i++) begin
            tick();
            check("exit_done_once", done, 0);
            check("exit_hold", estado, 5);
            if (full) check("exit_motor_hold", motor_esteira, 1);
        end
        sensor_garrafa = 1'b0;
        tick();
        check("after_exit", estado, start ? 1 : 0);
        check("after_done", done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        sensor_garrafa  = 1'b0;
        sensor_nivel    = 1'b0;
        rolhas_linha    = 8'd0;
        reconhece_falha = 1'b0;
        tick();
        tick();
        check("rst_estado", estado, 0);
        check("rst_outputs", {motor_esteira, valvula, vedar, done, alarme_sem_rolha, alarme_enchimento}, 0);
        check_counters();
        reset = 1'b0;
        tick();
        check("idle_hold", estado, 0);
        start = 1'b1;
        tick();
        check("transp_estado", estado, 1);
        check("transp_motor", motor_esteira, 1);

        // nominal bottle, no-cork wait, level exactly at the timeout cycle
        run_bottle(7, 1'b1, 0, 2, 1'b0, 1'b1);
        run_bottle(3, 1'b0, 4, 0, 1'b0, 1'b1);
        run_bottle(50, 1'b1, 0, 1, 1'b0, 1'b1);

        // fill timeout
        sensor_garrafa = 1'b1;
        sensor_nivel   = 1'b0;
        tick();
        check("to_enter", estado, 2);
        for (int i = 0; i < 49; i++) begin
            tick();
            check("to_hold", estado, 2);
        end
        tick();
        check("to_falha", estado, 6);
        check("to_alarme", alarme_enchimento, 1);
        check("to_actuators", {motor_esteira, valvula, vedar, done}, 0);
        tick();
        tick();
        check("to_latched", alarme_enchimento, 1);
        check_counters();
        reconhece_falha = 1'b1;
        tick();
        reconhece_falha = 1'b0;
        check("ack_estado", estado, 0);
        check("ack_alarme", alarme_enchimento, 0);
        sensor_garrafa = 1'b0;
        tick();
        check("ack_restart", estado, 1);

        // start dropped during fill: bottle completes, station parks in IDLE
        run_bottle(5, 1'b1, 0, 1, 1'b1, 1'b1);
        tick();
        check("stop_stay_idle", estado, 0);
        start = 1'b1;
        tick();
        check("stop_restart", estado, 1);

        for (int k = 0; k < 20; k++) begin
            run_bottle($urandom_range(1, 50), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
                       $urandom_range(0, 4), 1'b0, 1'b1);
        end

        // reset in the middle of corking
        sensor_garrafa = 1'b1;
        tick();
        sensor_nivel = 1'b1;
        rolhas_linha = 8'd5;
        tick();
        sensor_nivel = 1'b0;
        check("rv_cap", estado, 4);
        tick();
        reset = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b0;
        n_ok  = 0;
        check("rv_estado", estado, 0);
        check("rv_outputs", {motor_esteira, valvula, vedar, done, alarme_sem_rolha, alarme_enchimento}, 0);
        check_counters();
        tick();
        check("rv_no_done", done, 0);
        sensor_garrafa = 1'b0;
        start = 1'b1;
        tick();
        check("rv_restart", estado, 1);

        // rollover and saturation of the batch total
        while (n_ok < 12 * 256 + 3) begin
            run_bottle(1, 1'b1, 0, 0, 1'b0, 1'b0);
        end
        check("sat_lotes", lotes, 255);
        check("sat_garrafas", garrafas_lote, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
